// File: rtl/ref_force_wb_arbiter.sv
// Reference-force writeback arbiter.
// Collects accumulated reference-particle forces from NUM_ACC accumulator lanes, buffers
// them in per-lane FIFOs and serialises them round-robin onto one valid/ready port.
// Each writeback round (start_wb pulse until all lanes drained) is framed by a small FSM
// that counts accepted beats and pulses round_done when the round completes.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid, in_start_wb            per-lane push strobe / start-of-round strobe
//   in_id, in_force_x/y/z            per-lane packed entry payload
//   out_valid, out_ready             writeback handshake
//   out_id, out_force_x/y/z, out_src presented entry and the lane it came from
//   round_done, round_count          end-of-round pulse, beats accepted this/last round
//   overflow_err                     sticky per-lane FIFO overflow flags
module ref_force_wb_arbiter #(
  parameter int unsigned NUM_ACC    = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 29,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned SRC_WIDTH = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ACC-1:0]             in_valid,
  input  logic [NUM_ACC-1:0]             in_start_wb,
  input  logic [NUM_ACC*ID_WIDTH-1:0]    in_id,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]  in_force_x,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]  in_force_y,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]  in_force_z,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic [DATA_WIDTH-1:0]          out_force_x,
  output logic [DATA_WIDTH-1:0]          out_force_y,
  output logic [DATA_WIDTH-1:0]          out_force_z,
  output logic [SRC_WIDTH-1:0]           out_src,
  output logic                           round_done,
  output logic [CNT_WIDTH-1:0]           round_count,
  output logic [NUM_ACC-1:0]             overflow_err
);

  localparam int unsigned ENTRY_WIDTH = ID_WIDTH + 3 * DATA_WIDTH;
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = SRC_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  logic [NUM_ACC-1:0]     empty, full, push_req, push, pop, ovf_set;
  logic [ENTRY_WIDTH-1:0] head [NUM_ACC];

  logic                   grant_valid, load, accept;
  logic [SRC_WIDTH-1:0]   grant_idx;

  logic                   out_valid_q;
  logic [ENTRY_WIDTH-1:0] out_entry_q;
  logic [SRC_WIDTH-1:0]   out_src_q, rr_q;
  logic [NUM_ACC-1:0]     ovf_q;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // Per-lane FIFOs; pointers carry one extra wrap bit to tell full from empty.
  for (genvar i = 0; i < NUM_ACC; i++) begin : g_lane
    logic [AW:0]            wr_q, rd_q;
    logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                   nonzero;

    assign nonzero = |{in_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                       in_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                       in_force_z[i*DATA_WIDTH +: DATA_WIDTH]};

    assign empty[i]    = (wr_q == rd_q);
    assign full[i]     = (wr_q == {~rd_q[AW], rd_q[AW-1:0]});
    assign push_req[i] = in_valid[i] & nonzero;
    // A same-cycle pop frees the slot, so a full lane still accepts the push.
    assign push[i]     = push_req[i] & (~full[i] | pop[i]);
    assign ovf_set[i]  = push_req[i] & full[i] & ~pop[i];
    assign head[i]     = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push[i]) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
        if (pop[i])  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      end
    end

    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem_q[wr_q[AW-1:0]] <= {in_id[i*ID_WIDTH +: ID_WIDTH],
                                in_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                                in_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                                in_force_z[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Round-robin search over non-empty lanes, starting at rr_q.
  always_comb begin
    logic [CW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_ACC; k++) begin
      cand = {1'b0, rr_q} + CW'(k);
      if (cand >= CW'(NUM_ACC)) cand = cand - CW'(NUM_ACC);
      if (!grant_valid && !empty[cand[SRC_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SRC_WIDTH-1:0];
      end
    end
  end

  assign accept = out_valid_q & out_ready;
  assign load   = grant_valid & (~out_valid_q | out_ready);

  always_comb begin
    pop = '0;
    if (load) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      out_src_q   <= '0;
      rr_q        <= '0;
      ovf_q       <= '0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      if (load) begin
        out_valid_q <= 1'b1;
        out_entry_q <= head[grant_idx];
        out_src_q   <= grant_idx;
        rr_q        <= (grant_idx == SRC_WIDTH'(NUM_ACC - 1)) ? '0
                                                              : grant_idx + SRC_WIDTH'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|in_start_wb) begin
          state_d = StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (accept && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
        // Drained: nothing buffered, nothing presented, nothing arriving.
        if ((&empty) && !out_valid_q && (in_valid == '0)) state_d = StDone;
      end
      StDone: begin
        if (|in_start_wb) begin
          state_d = StActive;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_valid    = out_valid_q;
  assign out_id       = out_entry_q[ENTRY_WIDTH-1 -: ID_WIDTH];
  assign out_force_x  = out_entry_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_force_y  = out_entry_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_force_z  = out_entry_q[DATA_WIDTH-1:0];
  assign out_src      = out_src_q;
  assign round_done   = (state_q == StDone);
  assign round_count  = cnt_q;
  assign overflow_err = ovf_q;

endmodule
